// File: rtl/display_share_arbiter.sv
// Round-robin owner of a shared 6-digit 7-segment display with minimum hold time,
// direct preemption after the hold expires, and optional blinking of the owner's content.
module display_share_arbiter #(
  parameter int CLK_RATE_HZ   = 50_000_000,
  parameter int N_REQ         = 2,
  parameter int HOLD_MS       = 500,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [24*N_REQ-1:0]  req_data,
  input  logic [6*N_REQ-1:0]   req_digit_mask,
  input  logic [6*N_REQ-1:0]   req_dp_mask,
  input  logic [N_REQ-1:0]     req_blink,
  output logic [N_REQ-1:0]     grant,
  output logic [23:0]          data,
  output logic [5:0]           digit_enable_mask,
  output logic [5:0]           decimal_point_enable_mask,
  output logic                 busy
);

  localparam int TICK_DIV = (CLK_RATE_HZ / 1000 >= 1) ? CLK_RATE_HZ / 1000 : 1;
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PRE_W    = $clog2(TICK_DIV + 1);
  localparam int HOLD_W   = $clog2(HOLD_MS + 1);
  localparam int BLK_W    = $clog2(BLINK_HALF_MS + 1);

  localparam logic [PRE_W-1:0]  TICK_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_MS);
  localparam logic [BLK_W-1:0]  BLINK_LAST = BLK_W'(BLINK_HALF_MS - 1);
  localparam logic [IDX_W-1:0]  LAST_INIT  = IDX_W'(N_REQ - 1);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [23:0]        data_q, data_d;
  logic [5:0]         digit_q, digit_d;
  logic [5:0]         dp_q, dp_d;

  logic [23:0]        data_arr  [N_REQ];
  logic [5:0]         digit_arr [N_REQ];
  logic [5:0]         dp_arr    [N_REQ];

  logic               scan_found;
  logic [IDX_W-1:0]   scan_idx;
  logic               tick;
  logic               arm;
  logic               load;
  logic [IDX_W-1:0]   load_idx;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i]  = req_data[24*i +: 24];
      digit_arr[i] = req_digit_mask[6*i +: 6];
      dp_arr[i]    = req_dp_mask[6*i +: 6];
    end
  end

  // Scan starts just after the last owner; when only the owner requests, the scan
  // wraps back to the owner itself, which the OWNED state reads as "no other request".
  always_comb begin
    int pos;
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = int'(last_owner_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!scan_found && req[IDX_W'(pos)]) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    presc_d      = presc_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    data_d       = '0;
    digit_d      = '0;
    dp_d         = '0;
    arm          = 1'b0;
    load         = 1'b0;
    load_idx     = last_owner_q;
    tick         = (presc_q == TICK_LAST);

    case (state_q)
      ST_IDLE: begin
        if (scan_found) arm = 1'b1;
      end
      ST_OWNED: begin
        if (!req[last_owner_q]) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          hold_cnt_d  = '0;
          presc_d     = '0;
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end else if (hold_cnt_q == '0 && scan_found && scan_idx != last_owner_q) begin
          arm = 1'b1;
        end else begin
          presc_d = tick ? '0 : presc_q + PRE_W'(1);
          if (tick) begin
            if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
          end
          load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arm) begin
      state_d      = ST_OWNED;
      grant_d      = N_REQ'(1) << scan_idx;
      last_owner_d = scan_idx;
      hold_cnt_d   = HOLD_INIT;
      presc_d      = '0;
      blink_cnt_d  = '0;
      phase_d      = 1'b0;
      load         = 1'b1;
      load_idx     = scan_idx;
    end

    // Masks follow the phase being registered this edge so they line up with the tick.
    if (load) begin
      data_d = data_arr[load_idx];
      if (!(req_blink[load_idx] && phase_d)) begin
        digit_d = digit_arr[load_idx];
        dp_d    = dp_arr[load_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_owner_q <= LAST_INIT;
      hold_cnt_q   <= '0;
      presc_q      <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      data_q       <= '0;
      digit_q      <= '0;
      dp_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      presc_q      <= presc_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      data_q       <= data_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
    end
  end

  assign grant                     = grant_q;
  assign data                      = data_q;
  assign digit_enable_mask         = digit_q;
  assign decimal_point_enable_mask = dp_q;
  assign busy                      = |grant_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter: vector table, directed timing sequences and
// randomized traffic checked against an ownership/age reference model.
module tb_display_share_arbiter;

  localparam int CLK_RATE_HZ   = 10000;
  localparam int N_REQ         = 2;
  localparam int HOLD_MS       = 2;
  localparam int BLINK_HALF_MS = 1;
  localparam int TICK_DIV      = CLK_RATE_HZ / 1000;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [47:0] req_data;
  logic [11:0] req_digit_mask;
  logic [11:0] req_dp_mask;
  logic [1:0]  req_blink;
  logic [1:0]  grant;
  logic [23:0] data;
  logic [5:0]  digit_enable_mask;
  logic [5:0]  decimal_point_enable_mask;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  display_share_arbiter #(
    .CLK_RATE_HZ(CLK_RATE_HZ), .N_REQ(N_REQ), .HOLD_MS(HOLD_MS), .BLINK_HALF_MS(BLINK_HALF_MS)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_digit_mask(req_digit_mask), .req_dp_mask(req_dp_mask), .req_blink(req_blink),
    .grant(grant), .data(data), .digit_enable_mask(digit_enable_mask),
    .decimal_point_enable_mask(decimal_point_enable_mask), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, want $finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // Reference model: who owns the display and how many edges since the grant.
  int          m_owner = -1;
  int          m_last  = N_REQ - 1;
  int          m_age   = 0;
  int          m_nxt;
  int          m_idx;
  int          m_phase;
  logic [1:0]  m_grant;
  logic [23:0] m_data;
  logic [5:0]  m_dig;
  logic [5:0]  m_dp;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_last  = N_REQ - 1;
      m_age   = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        m_idx = (m_last + k) % N_REQ;
        if (m_owner < 0 && req[m_idx]) m_owner = m_idx;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_age  = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else begin
      m_nxt = -1;
      for (int k = 1; k < N_REQ; k++) begin
        m_idx = (m_owner + k) % N_REQ;
        if (m_nxt < 0 && req[m_idx]) m_nxt = m_idx;
      end
      if (m_age >= HOLD_MS * TICK_DIV && m_nxt >= 0) begin
        m_owner = m_nxt;
        m_last  = m_nxt;
        m_age   = 0;
      end else begin
        m_age++;
      end
    end
    if (m_owner < 0) begin
      m_grant = '0; m_data = '0; m_dig = '0; m_dp = '0;
    end else begin
      m_phase = ((m_age / TICK_DIV) / BLINK_HALF_MS) % 2;
      m_grant = 2'(1 << m_owner);
      m_data  = req_data[24*m_owner +: 24];
      m_dig   = (req_blink[m_owner] && m_phase == 1) ? 6'h00 : req_digit_mask[6*m_owner +: 6];
      m_dp    = (req_blink[m_owner] && m_phase == 1) ? 6'h00 : req_dp_mask[6*m_owner +: 6];
    end
  end

  // driver tasks
  task automatic drive(input logic rst, input logic [1:0] r,
                       input logic [23:0] d0, input logic [23:0] d1,
                       input logic [5:0] m0, input logic [5:0] m1,
                       input logic [5:0] p0, input logic [5:0] p1,
                       input logic [1:0] bl);
    reset          = rst;
    req            = r;
    req_data       = {d1, d0};
    req_digit_mask = {m1, m0};
    req_dp_mask    = {p1, p0};
    req_blink      = bl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [1:0] eg, input logic [23:0] ed,
                       input logic [5:0] em, input logic [5:0] ep);
    n_cmp++;
    if (grant !== eg || data !== ed || digit_enable_mask !== em ||
        decimal_point_enable_mask !== ep || busy !== (|eg)) begin
      n_bad++;
      $display("FAIL %s t=%0t: got grant=%b data=%h dig=%h dp=%h busy=%b, want grant=%b data=%h dig=%h dp=%h busy=%b",
               name, $time, grant, data, digit_enable_mask, decimal_point_enable_mask, busy,
               eg, ed, em, ep, |eg);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [23:0] d0, d1;
    logic [5:0]  m0, m1, p0, p1;
    logic [1:0]  blink;
    logic [1:0]  e_grant;
    logic [23:0] e_data;
    logic [5:0]  e_dig, e_dp;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] r, input logic [23:0] d0,
                              input logic [23:0] d1, input logic [5:0] m0, input logic [5:0] m1,
                              input logic [5:0] p0, input logic [5:0] p1, input logic [1:0] bl,
                              input logic [1:0] eg, input logic [23:0] ed, input logic [5:0] em,
                              input logic [5:0] ep);
    vec_t v;
    v.rst = rst; v.req = r; v.d0 = d0; v.d1 = d1; v.m0 = m0; v.m1 = m1;
    v.p0 = p0; v.p1 = p1; v.blink = bl;
    v.e_grant = eg; v.e_data = ed; v.e_dig = em; v.e_dp = ep;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [1:0]  eg;
    logic [23:0] ed;
    logic [5:0]  em, ep;
    logic [1:0]  r;
    logic [23:0] d0, d1;
    logic [5:0]  m0, m1, p0, p1;
    logic [1:0]  bl;

    // reset, first grant, live update, owner drop with blank cycle, RR restart, masks
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0,                              2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0,                              2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0,                              2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 24'h123456, 24'h0, 6'h3F, 0, 6'h15, 0, 0,         2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 24'h123456, 24'h0, 6'h3F, 0, 6'h15, 0, 0,         2'b01, 24'h123456, 6'h3F, 6'h15));
    vecs.push_back(mk(0, 2'b01, 24'hABCDEF, 24'h0, 6'h3F, 0, 6'h15, 0, 0,         2'b01, 24'hABCDEF, 6'h3F, 6'h15));
    vecs.push_back(mk(0, 2'b11, 24'hABCDEF, 24'h654321, 6'h3F, 6'h0F, 6'h15, 6'h01, 0, 2'b01, 24'hABCDEF, 6'h3F, 6'h15));
    vecs.push_back(mk(0, 2'b10, 24'hABCDEF, 24'h654321, 6'h3F, 6'h0F, 6'h15, 6'h01, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 24'hABCDEF, 24'h654321, 6'h3F, 6'h0F, 6'h15, 6'h01, 0, 2'b10, 24'h654321, 6'h0F, 6'h01));
    vecs.push_back(mk(0, 2'b00, 24'hABCDEF, 24'h654321, 6'h3F, 6'h0F, 6'h15, 6'h01, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 24'hABCDEF, 24'h654321, 6'h3F, 6'h0F, 6'h15, 6'h01, 0, 2'b01, 24'hABCDEF, 6'h3F, 6'h15));
    vecs.push_back(mk(0, 2'b11, 24'hABCDEF, 24'hFFFFFF, 6'h3F, 6'h3F, 6'h15, 6'h3F, 2'b10, 2'b01, 24'hABCDEF, 6'h3F, 6'h15));
    vecs.push_back(mk(0, 2'b01, 24'hABCDEF, 24'hFFFFFF, 6'h00, 6'h3F, 6'h3F, 6'h3F, 0, 2'b01, 24'hABCDEF, 6'h00, 6'h3F));
    vecs.push_back(mk(0, 2'b00, 24'hABCDEF, 24'hFFFFFF, 6'h00, 6'h3F, 6'h3F, 6'h3F, 0, 2'b00, 0, 0, 0));

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].m0, vecs[i].m1,
            vecs[i].p0, vecs[i].p1, vecs[i].blink);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_data, vecs[i].e_dig, vecs[i].e_dp);
    end

    // rotation: requester 0 owns edges 0..20, requester 1 takes over with no blank cycle
    drive(1, 2'b00, 24'h111111, 24'h222222, 6'h3F, 6'h07, 6'h00, 6'h38, 0);
    step(); step();
    check("rot_reset", 2'b00, 0, 0, 0);
    drive(0, 2'b11, 24'h111111, 24'h222222, 6'h3F, 6'h07, 6'h00, 6'h38, 0);
    for (int e = 0; e <= 42; e++) begin
      step();
      if (e <= 20 || e >= 42) check($sformatf("rot_e%0d", e), 2'b01, 24'h111111, 6'h3F, 6'h00);
      else                    check($sformatf("rot_e%0d", e), 2'b10, 24'h222222, 6'h07, 6'h38);
    end

    // blink: digit/dp masks alternate every TICK_DIV edges, data untouched
    drive(1, 2'b00, 24'hC0FFEE, 24'h0, 6'h3F, 0, 6'h2A, 0, 2'b01);
    step();
    drive(0, 2'b01, 24'hC0FFEE, 24'h0, 6'h3F, 0, 6'h2A, 0, 2'b01);
    for (int e = 0; e < 40; e++) begin
      step();
      if (((e / 10) % 2) == 1) check($sformatf("blink_e%0d", e), 2'b01, 24'hC0FFEE, 6'h00, 6'h00);
      else                     check($sformatf("blink_e%0d", e), 2'b01, 24'hC0FFEE, 6'h3F, 6'h2A);
    end

    // reset mid-hold, then requester 0 wins again
    drive(1, 2'b00, 24'h0A0A0A, 24'h0B0B0B, 6'h01, 6'h02, 6'h04, 6'h08, 0);
    step();
    drive(0, 2'b11, 24'h0A0A0A, 24'h0B0B0B, 6'h01, 6'h02, 6'h04, 6'h08, 0);
    step(); step(); step();
    drive(0, 2'b10, 24'h0A0A0A, 24'h0B0B0B, 6'h01, 6'h02, 6'h04, 6'h08, 0);
    step(); step();
    check("pre_reset_owner1", 2'b10, 24'h0B0B0B, 6'h02, 6'h08);
    drive(1, 2'b11, 24'h0A0A0A, 24'h0B0B0B, 6'h01, 6'h02, 6'h04, 6'h08, 0);
    step();
    check("mid_reset", 2'b00, 0, 0, 0);
    drive(0, 2'b11, 24'h0A0A0A, 24'h0B0B0B, 6'h01, 6'h02, 6'h04, 6'h08, 0);
    step();
    check("after_reset", 2'b01, 24'h0A0A0A, 6'h01, 6'h04);

    // randomized traffic against the reference model
    r = 2'b00; d0 = $urandom; d1 = $urandom; m0 = 6'h3F; m1 = 6'h3F; p0 = 0; p1 = 0; bl = 0;
    drive(1, r, d0, d1, m0, m1, p0, p1, bl);
    step(); step();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 29) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 3) == 0) d0 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) d1 = 24'($urandom);
      if ($urandom_range(0, 15) == 0) begin m0 = 6'($urandom); p1 = 6'($urandom); end
      if ($urandom_range(0, 15) == 0) begin m1 = 6'($urandom); p0 = 6'($urandom); end
      if ($urandom_range(0, 99) == 0) bl = 2'($urandom);
      drive($urandom_range(0, 399) == 0, r, d0, d1, m0, m1, p0, p1, bl);
      step();
      eg = m_grant; ed = m_data; em = m_dig; ep = m_dp;
      check($sformatf("rand%0d", c), eg, ed, em, ep);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
